// File: rtl/capture_pkg.sv
// Shared types and helpers for the sample capture front end.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    CAPTURE  = 2'd2,
    OVERFLOW = 2'd3
  } state_e;

  localparam logic [1:0] MODE_FULL    = 2'd0;
  localparam logic [1:0] MODE_HALF    = 2'd1;
  localparam logic [1:0] MODE_QUARTER = 2'd2;

  // Samples packed into one output word; mode 3 behaves like full width.
  function automatic logic [2:0] samples_per_word(input logic [1:0] mode);
    case (mode)
      MODE_HALF:    return 3'd2;
      MODE_QUARTER: return 3'd4;
      default:      return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/capture_packer.sv
// Packs 1, 2 or 4 narrow samples into one NUM_CH-wide word, earliest sample in the low bits.
// `word` is the word as it would look after the current load; `word_done` marks the load that completes it.
module capture_packer
  import capture_pkg::*;
#(
  parameter int NUM_CH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [1:0]        mode,
  input  logic [NUM_CH-1:0] sample,
  output logic [NUM_CH-1:0] word,
  output logic              word_done
);

  localparam int HALF_W = NUM_CH / 2;
  localparam int QUAR_W = NUM_CH / 4;

  logic [NUM_CH-1:0] acc_q, acc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0]        spw;

  // Slot insertion, completion detect and next accumulator state.
  always_comb begin
    spw  = samples_per_word(mode);
    word = acc_q;
    case (mode)
      MODE_HALF:    word[int'(cnt_q[0]) * HALF_W +: HALF_W] = sample[HALF_W-1:0];
      MODE_QUARTER: word[int'(cnt_q) * QUAR_W +: QUAR_W]    = sample[QUAR_W-1:0];
      default:      word = sample;
    endcase
    word_done = load && !clear && ({1'b0, cnt_q} == (spw - 3'd1));

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (load) begin
      if (word_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = word;
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  // Accumulator and sample-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sample_capture.sv
// Acquisition front end: probe synchroniser, rate divider, mask/value trigger and capture FSM
// feeding packed words to the FIFO write side.
module sample_capture
  import capture_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] probe,
  input  logic              enable,
  input  logic [DIV_W-1:0]  divisor,
  input  logic [1:0]        ch_mode,
  input  logic [NUM_CH-1:0] trig_mask,
  input  logic [NUM_CH-1:0] trig_value,
  input  logic              fifo_full,
  output logic [NUM_CH-1:0] sample_data,
  output logic              sample_data_avail,
  output logic              running,
  output logic              triggered,
  output logic              overflow
);

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] sync1_q, sync_q;
  logic [DIV_W-1:0]  div_q, div_d, cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [NUM_CH-1:0] data_q, data_d;
  logic              avail_q, avail_d, ovf_q, ovf_d;
  logic              active, tick, trig_hit;
  logic              pk_clear, pk_load, pk_done;
  logic [NUM_CH-1:0] pk_word;

  assign active   = (state_q == ARMED) || (state_q == CAPTURE);
  assign tick     = active && (cnt_q == '0);
  assign trig_hit = ((sync_q ^ trig_value) & trig_mask) == '0;
  // In ARMED the matching tick's sample is already the first one captured.
  assign pk_load  = enable && tick && ((state_q == CAPTURE) || trig_hit);
  // Partial words never survive a stop or a pass through IDLE.
  assign pk_clear = (state_q == IDLE) || !enable;

  capture_packer #(.NUM_CH(NUM_CH)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .load      (pk_load),
    .mode      (mode_q),
    .sample    (sync_q),
    .word      (pk_word),
    .word_done (pk_done)
  );

  // Two-flop synchroniser on the raw probe pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= probe;
      sync_q  <= sync1_q;
    end
  end

  // Next-state, divider, config latch and output-word logic.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    avail_d = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = ARMED;
          div_d   = divisor;
          mode_d  = ch_mode;
          cnt_d   = divisor;
          ovf_d   = 1'b0;
        end
      end
      ARMED, CAPTURE: begin
        cnt_d = tick ? div_q : (cnt_q - CNT_ONE);
        if (!enable) begin
          state_d = IDLE;
        end else if (pk_load) begin
          state_d = CAPTURE;
          if (pk_done) begin
            if (fifo_full) begin
              state_d = OVERFLOW;
              ovf_d   = 1'b1;
            end else begin
              data_d  = pk_word;
              avail_d = 1'b1;
            end
          end
        end
      end
      OVERFLOW: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, configuration and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      mode_q  <= MODE_FULL;
      cnt_q   <= '0;
      data_q  <= '0;
      avail_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      avail_q <= avail_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sample_data       = data_q;
  assign sample_data_avail = avail_q;
  assign running           = active;
  assign triggered         = (state_q == CAPTURE);
  assign overflow          = ovf_q;

endmodule

// File: tb/tb_sample_capture.sv
// Scoreboard bench for sample_capture: expected words are queued as stimulus is
// driven and popped whenever the DUT strobes sample_data_avail.
module tb_sample_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] probe, trig_mask, trig_value, divisor;
  logic        enable, fifo_full;
  logic [1:0]  ch_mode;
  logic [15:0] sample_data;
  logic        sample_data_avail, running, triggered, overflow;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  int          arm_cyc;
  logic [15:0] exp_q[$];
  int          strobe_cyc_q[$];

  sample_capture #(.NUM_CH(16), .DIV_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .probe             (probe),
    .enable            (enable),
    .divisor           (divisor),
    .ch_mode           (ch_mode),
    .trig_mask         (trig_mask),
    .trig_value        (trig_value),
    .fifo_full         (fifo_full),
    .sample_data       (sample_data),
    .sample_data_avail (sample_data_avail),
    .running           (running),
    .triggered         (triggered),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (sample_data_avail === 1'b1) begin
      strobe_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_strobe", {31'd0, sample_data_avail}, 32'd0);
      else check("sample_data", {16'd0, sample_data}, {16'd0, exp_q.pop_front()});
    end
  end

  // Outputs observed right after this call reflect the edge just taken.
  task automatic step(input logic [15:0] p, input logic en);
    @(posedge clk);
    #1;
    probe  = p;
    enable = en;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(probe, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; probe = '0; enable = 1'b0; divisor = '0; ch_mode = 2'd0;
    trig_mask = '0; trig_value = '0; fifo_full = 1'b0;
    #12;
    check("rst_data",      {16'd0, sample_data}, 32'd0);
    check("rst_avail",     {31'd0, sample_data_avail}, 32'd0);
    check("rst_running",   {31'd0, running}, 32'd0);
    check("rst_triggered", {31'd0, triggered}, 32'd0);
    check("rst_overflow",  {31'd0, overflow}, 32'd0);
    #1 rst = 1'b0;
    idle(2);

    // Immediate trigger, ramp, one strobe per cycle
    for (int i = 1; i <= 10; i++) exp_q.push_back(16'(i));
    strobe_cyc_q.delete();
    for (int i = 0; i <= 12; i++) begin
      step(16'(i + 1), (i >= 1) && (i < 12));
      if (i == 2) check("imm_trig_before", {31'd0, triggered}, 32'd0);
      if (i == 3) check("imm_trig_first",  {31'd0, triggered}, 32'd1);
    end
    idle(3);
    check("imm_strobe_count", strobe_cyc_q.size(), 32'd10);
    if (strobe_cyc_q.size() == 10)
      check("imm_back_to_back", strobe_cyc_q[9] - strobe_cyc_q[0], 32'd9);
    check("imm_data_hold", {16'd0, sample_data}, 32'h000A);
    check("imm_stopped",   {31'd0, running}, 32'd0);

    // Divider: divisor 3, constant probe
    divisor = 16'd3;
    step(16'hA5A5, 1'b0);
    step(16'hA5A5, 1'b0);
    repeat (4) exp_q.push_back(16'hA5A5);
    strobe_cyc_q.delete();
    step(16'hA5A5, 1'b1);
    arm_cyc = cyc;
    repeat (16) step(16'hA5A5, 1'b1);
    step(16'hA5A5, 1'b0);
    idle(6);
    check("div_strobe_count", strobe_cyc_q.size(), 32'd4);
    if (strobe_cyc_q.size() > 0)
      check("div_first_latency", strobe_cyc_q[0] - arm_cyc, 32'd5);
    for (int k = 1; k < strobe_cyc_q.size(); k++)
      check("div_spacing", strobe_cyc_q[k] - strobe_cyc_q[k-1], 32'd4);

    // Trigger on bit0 rising after 10 non-matching ticks
    divisor = 16'd0; trig_mask = 16'h0001; trig_value = 16'h0001;
    step(16'h0000, 1'b0);
    step(16'h0000, 1'b0);
    exp_q.push_back(16'h0015); exp_q.push_back(16'h0017);
    exp_q.push_back(16'h0019); exp_q.push_back(16'h001B);
    for (int i = 0; i <= 16; i++) begin
      step(16'((i << 1) | ((i >= 10) ? 1 : 0)), (i >= 1) && (i < 16));
      if (i == 12) begin
        check("trg_wait_running",   {31'd0, running}, 32'd1);
        check("trg_wait_triggered", {31'd0, triggered}, 32'd0);
      end
      if (i == 13) check("trg_rise", {31'd0, triggered}, 32'd1);
    end
    idle(3);
    trig_mask = 16'h0000; trig_value = 16'h0000;

    // Packing: quarter mode then half mode
    ch_mode = 2'd2;
    exp_q.push_back(16'h4321);
    for (int i = 0; i <= 6; i++)
      step((i < 4) ? 16'(16'hABC0 + i + 1) : 16'h0000, (i >= 1) && (i < 6));
    idle(3);
    ch_mode = 2'd1;
    exp_q.push_back(16'h3412);
    for (int i = 0; i <= 5; i++)
      step((i == 0) ? 16'hFF12 : ((i == 1) ? 16'hEE34 : 16'h0000), (i >= 1) && (i < 5));
    idle(3);
    check("pack_queue_drained", exp_q.size(), 32'd0);

    // Overflow at word completion
    ch_mode = 2'd0; fifo_full = 1'b1;
    step(16'h1111, 1'b0);
    step(16'h1111, 1'b1);
    step(16'h1111, 1'b1);
    step(16'h1111, 1'b1);
    check("ovf_flag",      {31'd0, overflow}, 32'd1);
    check("ovf_running",   {31'd0, running}, 32'd0);
    check("ovf_triggered", {31'd0, triggered}, 32'd0);
    step(16'h1111, 1'b0);
    step(16'h1111, 1'b0);
    check("ovf_idle_sticky", {31'd0, overflow}, 32'd1);
    check("ovf_idle_running", {31'd0, running}, 32'd0);
    fifo_full = 1'b0;
    step(16'h1111, 1'b1);
    step(16'h1111, 1'b0);
    check("ovf_rearm_clear",   {31'd0, overflow}, 32'd0);
    check("ovf_rearm_running", {31'd0, running}, 32'd1);
    idle(2);

    // enable=0 and fifo_full in the same completing cycle: stop wins
    fifo_full = 1'b1;
    step(16'h2222, 1'b1);
    step(16'h2222, 1'b0);
    step(16'h2222, 1'b0);
    check("stop_wins_ovf", {31'd0, overflow}, 32'd0);
    check("stop_wins_run", {31'd0, running}, 32'd0);
    fifo_full = 1'b0;
    idle(2);

    // Abort after 2 of 4 samples, then a clean word proves the partial was dropped
    ch_mode = 2'd2;
    step(16'h0007, 1'b1);
    step(16'h0007, 1'b1);
    step(16'h0007, 1'b1);
    step(16'h0007, 1'b0);
    check("abort_running_before", {31'd0, running}, 32'd1);
    step(16'h0007, 1'b0);
    check("abort_idle", {31'd0, running}, 32'd0);
    idle(2);
    exp_q.push_back(16'h4321);
    for (int i = 0; i <= 6; i++)
      step((i < 4) ? 16'(i + 1) : 16'h0000, (i >= 1) && (i < 6));
    idle(3);

    // Async reset mid-capture
    ch_mode = 2'd0;
    step(16'h5A5A, 1'b0);
    step(16'h5A5A, 1'b0);
    exp_q.push_back(16'h5A5A); exp_q.push_back(16'h5A5A);
    repeat (4) step(16'h5A5A, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_data",      {16'd0, sample_data}, 32'd0);
    check("arst_avail",     {31'd0, sample_data_avail}, 32'd0);
    check("arst_running",   {31'd0, running}, 32'd0);
    check("arst_triggered", {31'd0, triggered}, 32'd0);
    check("arst_overflow",  {31'd0, overflow}, 32'd0);
    enable = 1'b0;
    #3 rst = 1'b0;
    idle(3);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
